// File: rtl/hdr_flit_lk_route_ovc_update.sv
// ---------------------------------------------------------------------------
// hdr_flit_lk_route_ovc_update
//
// Router output-stage flit rewriter. Every flit leaving the port gets the
// output VC assigned to the input VC that won switch allocation. Header flits
// additionally get their destination-port field replaced by the look-ahead
// route. Switch traversal happens one cycle after allocation, so the granted
// input VC is registered here (vc_d) and used to pick the per-VC look-ahead
// route and output VC while the flit itself passes through combinationally.
//
// Optional feature macro: HDR_SSA_BYPASS_EN
//   When defined, the switch-grant flag is also registered (gnt_d). If no
//   input VC was granted last cycle, the unregistered look-ahead destination
//   is used instead of the muxed one. This supports single-cycle speculative
//   switch allocation. When undefined, any_ivc_sw_request_granted and
//   lk_dest_not_registered are ignored.
//
// Ports:
//   clk                         rising-edge clock
//   reset                       asynchronous, active-low reset
//   flit_in      [Fw-1:0]       {hdr, tail, vc[V-1:0], payload[FPAYw-1:0]}
//   vc_num_in    [V-1:0]        one-hot granted input VC, one cycle ahead
//   lk_dest_all_in [V*DSTPw-1:0] per-VC look-ahead destination
//   assigned_ovc_num [V*V-1:0]  per-input-VC assigned output VC
//   sel          [V-1:0]        per-VC adaptive axis select
//   any_ivc_sw_request_granted  some input VC won switch allocation
//   lk_dest_not_registered [DSTPw-1:0] unregistered look-ahead destination
//   flit_out     [Fw-1:0]       rewritten flit (combinational)
// ---------------------------------------------------------------------------
module hdr_flit_lk_route_ovc_update #(
  parameter int V          = 4,
  parameter int P          = 5,
  parameter int Fw         = 36,
  parameter int DSTPw      = 4,
  parameter int DST_P_LSB  = 8,
  parameter int ADAPTIVE   = 1,
  parameter int MULTI_FLIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [Fw-1:0]        flit_in,
  input  logic [V-1:0]         vc_num_in,
  input  logic [V*DSTPw-1:0]   lk_dest_all_in,
  input  logic [V*V-1:0]       assigned_ovc_num,
  input  logic [V-1:0]         sel,
  input  logic                 any_ivc_sw_request_granted,
  input  logic [DSTPw-1:0]     lk_dest_not_registered,
  output logic [Fw-1:0]        flit_out
);

  localparam int FPAYw     = Fw - 2 - V;
  localparam int DST_P_MSB = DST_P_LSB + DSTPw - 1;

  // Port count only matters to the adaptive encoding's meaning, not to logic.
  localparam int unused_port_count = P;

  // One-hot mux of per-VC destination slices; multi-hot ORs, no priority.
  function automatic logic [DSTPw-1:0] onehot_mux_dst(
    input logic [V*DSTPw-1:0] data,
    input logic [V-1:0]       s
  );
    logic [DSTPw-1:0] r;
    r = {DSTPw{1'b0}};
    for (int i = 0; i < V; i++) begin
      r = r | (data[i*DSTPw +: DSTPw] & {DSTPw{s[i]}});
    end
    return r;
  endfunction

  // One-hot mux of per-VC output-VC slices; multi-hot ORs, no priority.
  function automatic logic [V-1:0] onehot_mux_vc(
    input logic [V*V-1:0] data,
    input logic [V-1:0]   s
  );
    logic [V-1:0] r;
    r = {V{1'b0}};
    for (int i = 0; i < V; i++) begin
      r = r | (data[i*V +: V] & {V{s[i]}});
    end
    return r;
  endfunction

  logic [V-1:0]     vc_d;
  logic [DSTPw-1:0] lk_mux;
  logic [V-1:0]     ovc;
  logic [DSTPw-1:0] lk_dest;
  logic [DSTPw-1:0] dest_coded;
  logic             hdr;
  logic             unused_bits;

  // Hold the granted input VC for the flit that traverses next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vc_d <= {V{1'b0}};
    end else begin
      vc_d <= vc_num_in;
    end
  end

  assign lk_mux = onehot_mux_dst(lk_dest_all_in, vc_d);
  assign ovc    = onehot_mux_vc(assigned_ovc_num, vc_d);
  assign hdr    = (MULTI_FLIT != 0) ? flit_in[Fw-1] : 1'b1;

`ifdef HDR_SSA_BYPASS_EN
  logic gnt_d;

  // Remember whether allocation granted anything last cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_d <= 1'b0;
    end else begin
      gnt_d <= any_ivc_sw_request_granted;
    end
  end

  // No grant last cycle means the flit came through the speculative path,
  // so its route has not been through the look-ahead FIFO yet.
  assign lk_dest = gnt_d ? lk_mux : lk_dest_not_registered;

  assign unused_bits = ^flit_in[FPAYw+V-1:FPAYw];
`else
  assign lk_dest = lk_mux;

  assign unused_bits = ^{flit_in[FPAYw+V-1:FPAYw],
                         any_ivc_sw_request_granted,
                         lk_dest_not_registered};
`endif

  // Adaptive coding: the low two bits keep the flit's own value unless this
  // VC's axis select is set.
  always_comb begin
    dest_coded = lk_dest;
    if ((ADAPTIVE != 0) && !(|(sel & vc_d))) begin
      dest_coded[1:0] = flit_in[DST_P_LSB+1:DST_P_LSB];
    end else begin
      dest_coded[1:0] = lk_dest[1:0];
    end
  end

  // Insert the output VC on every flit; rewrite the destination on headers.
  always_comb begin
    flit_out = {flit_in[Fw-1:Fw-2], ovc, flit_in[FPAYw-1:0]};
    if (hdr) begin
      flit_out[DST_P_MSB:DST_P_LSB] = dest_coded;
    end else begin
      flit_out[DST_P_MSB:DST_P_LSB] = flit_in[DST_P_MSB:DST_P_LSB];
    end
  end

endmodule

// File: tb/tb_hdr_flit_lk_route_ovc_update.sv
// ---------------------------------------------------------------------------
// Testbench for hdr_flit_lk_route_ovc_update. Two instances run side by side
// on shared stimulus: one adaptive (ADAPTIVE=1), one deterministic
// (ADAPTIVE=0). Directed steps follow the block's intended use cases, then
// randomized traffic is checked against a behavioural model of the rewrite.
// ---------------------------------------------------------------------------
module tb_hdr_flit_lk_route_ovc_update;

  logic        clk;
  logic        reset;
  logic [35:0] flit_in;
  logic [3:0]  vc_num_in;
  logic [15:0] lk_dest_all_in;
  logic [15:0] assigned_ovc_num;
  logic [3:0]  sel;
  logic        any_ivc_sw_request_granted;
  logic [3:0]  lk_dest_not_registered;
  logic [35:0] flit_out_a;
  logic [35:0] flit_out_d;

  int checks;
  int errors;

  // Model state: what the design should have registered at the last edge.
  logic [3:0] m_vc;
  logic       m_gnt;

  hdr_flit_lk_route_ovc_update #(.ADAPTIVE(1)) dut_a (
    .clk(clk), .reset(reset), .flit_in(flit_in), .vc_num_in(vc_num_in),
    .lk_dest_all_in(lk_dest_all_in), .assigned_ovc_num(assigned_ovc_num),
    .sel(sel), .any_ivc_sw_request_granted(any_ivc_sw_request_granted),
    .lk_dest_not_registered(lk_dest_not_registered), .flit_out(flit_out_a)
  );

  hdr_flit_lk_route_ovc_update #(.ADAPTIVE(0)) dut_d (
    .clk(clk), .reset(reset), .flit_in(flit_in), .vc_num_in(vc_num_in),
    .lk_dest_all_in(lk_dest_all_in), .assigned_ovc_num(assigned_ovc_num),
    .sel(sel), .any_ivc_sw_request_granted(any_ivc_sw_request_granted),
    .lk_dest_not_registered(lk_dest_not_registered), .flit_out(flit_out_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected flit: VC field [33:30], destination field [11:8], header bit 35.
  function automatic logic [35:0] model(input bit adaptive);
    logic [35:0] r;
    logic [3:0]  ovc;
    logic [3:0]  lk;
    logic [3:0]  dest;
    ovc = 4'd0;
    lk  = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (m_vc[i]) begin
        ovc = ovc | assigned_ovc_num[i*4 +: 4];
        lk  = lk  | lk_dest_all_in[i*4 +: 4];
      end
    end
`ifdef HDR_SSA_BYPASS_EN
    if (!m_gnt) lk = lk_dest_not_registered;
`endif
    dest = lk;
    if (adaptive && ((sel & m_vc) == 4'd0)) dest[1:0] = flit_in[9:8];
    r = flit_in;
    r[33:30] = ovc;
    if (flit_in[35]) r[11:8] = dest;
    return r;
  endfunction

  task automatic cmp36(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Clock edge with the model tracking what gets registered.
  task automatic tick();
    logic [3:0] v;
    logic       g;
    v = vc_num_in;
    g = any_ivc_sw_request_granted;
    @(posedge clk);
    if (reset) begin
      m_vc  = v;
      m_gnt = g;
    end else begin
      m_vc  = 4'd0;
      m_gnt = 1'b0;
    end
    #1;
  endtask

  task automatic check_both(input string tag);
    #1;
    cmp36({tag, "_adaptive"}, flit_out_a, model(1'b1));
    cmp36({tag, "_determ"},   flit_out_d, model(1'b0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_vc   = 4'd0;
    m_gnt  = 1'b0;

    // Reset: VC field and deterministic dest are zero, adaptive keeps low bits.
    reset                      = 1'b0;
    vc_num_in                  = 4'b0001;
    lk_dest_all_in             = 16'h7B3C;
    assigned_ovc_num           = 16'h8421;
    sel                        = 4'b0000;
    any_ivc_sw_request_granted = 1'b1;
    lk_dest_not_registered     = 4'h0;
    flit_in                    = 36'h8_1234_5F67;
    flit_in[35]                = 1'b1;
    flit_in[11:8]              = 4'hF;
    tick();
    tick();
    check_both("reset");
    cmp4("reset_vc_field", flit_out_d[33:30], 4'h0);
    cmp4("reset_dest_determ", flit_out_d[11:8], 4'h0);
    cmp4("reset_dest_adaptive", flit_out_a[11:8], 4'h3);

    // Release reset; vc 0001 gets registered at the next edge.
    reset = 1'b1;
    #2;
    tick();
    check_both("vc0");
    cmp4("vc0_vc_field", flit_out_d[33:30], assigned_ovc_num[3:0]);

    // Deterministic header rewrite through VC 2.
    vc_num_in              = 4'b0100;
    lk_dest_all_in[11:8]   = 4'hA;
    assigned_ovc_num[11:8] = 4'b0010;
    tick();
    flit_in       = 36'h8_0F0F_0F0F;
    flit_in[35]   = 1'b1;
    check_both("hdr_vc2");
    cmp4("hdr_vc2_dest", flit_out_d[11:8], 4'hA);
    cmp4("hdr_vc2_vc", flit_out_d[33:30], 4'b0010);
    cmp36("hdr_vc2_rest", flit_out_d & ~36'h3_C000_0F00, flit_in & ~36'h3_C000_0F00);

    // Body flit: only the VC field changes.
    flit_in       = 36'h4_5555_5355;
    flit_in[35]   = 1'b0;
    flit_in[11:8] = 4'h3;
    check_both("body_vc2");
    cmp4("body_vc2_dest", flit_out_d[11:8], 4'h3);
    cmp36("body_vc2_rest", flit_out_d & ~36'h3_C000_0000, flit_in & ~36'h3_C000_0000);

    // Adaptive coding via VC 1.
    vc_num_in            = 4'b0010;
    lk_dest_all_in[7:4]  = 4'b1101;
    tick();
    flit_in       = 36'h8_0000_0000;
    flit_in[11:8] = 4'b0010;
    sel           = 4'b0010;
    check_both("adapt_sel");
    cmp4("adapt_sel_dest", flit_out_a[11:8], 4'b1101);
    sel = 4'b0000;
    check_both("adapt_nosel");
    cmp4("adapt_nosel_dest", flit_out_a[11:8], 4'b1110);

    // Multi-hot select ORs the slices.
    vc_num_in           = 4'b0011;
    lk_dest_all_in[3:0] = 4'h1;
    lk_dest_all_in[7:4] = 4'h2;
    sel                 = 4'b0011;
    tick();
    check_both("multihot");
    cmp4("multihot_dest_determ", flit_out_d[11:8], 4'h3);
    cmp4("multihot_dest_adaptive", flit_out_a[11:8], 4'h3);

    // No VC selected: dest and VC field go to zero.
    vc_num_in = 4'b0000;
    tick();
    check_both("novc");
    cmp4("novc_dest", flit_out_d[11:8], 4'h0);
    cmp4("novc_vc", flit_out_d[33:30], 4'h0);

`ifdef HDR_SSA_BYPASS_EN
    // Speculative bypass: no grant last cycle selects the unregistered dest.
    vc_num_in                  = 4'b0100;
    any_ivc_sw_request_granted = 1'b0;
    lk_dest_not_registered     = 4'h5;
    tick();
    check_both("bypass_nogrant");
    cmp4("bypass_nogrant_dest", flit_out_d[11:8], 4'h5);
    any_ivc_sw_request_granted = 1'b1;
    tick();
    check_both("bypass_grant");
    cmp4("bypass_grant_dest", flit_out_d[11:8], lk_dest_all_in[11:8]);
`endif

    // Randomized traffic, including multi-hot and empty selects.
    for (int n = 0; n < 80; n++) begin
      vc_num_in                  = 4'($urandom_range(0, 15));
      any_ivc_sw_request_granted = 1'($urandom_range(0, 1));
      tick();
      lk_dest_all_in         = 16'($urandom);
      assigned_ovc_num       = 16'($urandom);
      sel                    = 4'($urandom_range(0, 15));
      lk_dest_not_registered = 4'($urandom_range(0, 15));
      flit_in                = {4'($urandom_range(0, 15)), 32'($urandom)};
      check_both("random");
    end

    // Reset reasserted mid-run clears the registered VC immediately.
    reset = 1'b0;
    m_vc  = 4'd0;
    m_gnt = 1'b0;
    check_both("reset_again");
    cmp4("reset_again_vc", flit_out_a[33:30], 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdr_flit_lk_route_ovc_update.md
Name: hdr_flit_lk_route_ovc_update

Overview:
- Router output-stage block that rewrites each outgoing flit before it leaves on a port.
- Inserts the assigned output-VC number into every flit.
- On header flits only, replaces the destination-port field with the look-ahead route.
- The look-ahead route and output VC are picked per input VC, using a VC select registered one cycle earlier, because switch traversal happens one cycle after VC/switch allocation.

Parameters:
- V, 4: number of virtual channels; VC field width, one-hot.
- P, 5: router port count; informational, for adaptive encoding.
- Fw, 36: flit width.
- DSTPw, 4: destination-port field width.
- DST_P_LSB, 8: LSB of destination-port field. Requires DST_P_LSB+DSTPw <= FPAYw.
- ADAPTIVE, 1: 1 = coded adaptive destination field; 0 = deterministic (plain copy).
- MULTI_FLIT, 1: 1 = header flag taken from flit bit Fw-1; 0 = every flit is a header.
- Derived: FPAYw = Fw-2-V; DST_P_MSB = DST_P_LSB+DSTPw-1.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- flit_in, input, Fw: [Fw-1] = hdr, [Fw-2] = tail, [FPAYw+V-1:FPAYw] = VC, [FPAYw-1:0] = payload.
- vc_num_in, input, V: one-hot granted input VC, presented one cycle before its flit.
- lk_dest_all_in, input, V*DSTPw: per-VC look-ahead dest; slice i = [i*DSTPw +: DSTPw].
- assigned_ovc_num, input, V*V: per-input-VC assigned output VC; slice i = [i*V +: V].
- sel, input, V: per-VC adaptive axis select.
- any_ivc_sw_request_granted, input, 1: some input VC won switch allocation this cycle.
- lk_dest_not_registered, input, DSTPw: unregistered look-ahead dest, used by the speculative bypass.
- flit_out, output, Fw: rewritten flit, combinational.

Behaviour:
- Registers, both asynchronously cleared to 0 while reset = 0 and loaded on each rising clk:
  - vc_d <= vc_num_in.
  - gnt_d <= any_ivc_sw_request_granted (only when HDR_SSA_BYPASS_EN is defined).
- One-hot mux function: output = OR over i of (slice i AND {W{s[i]}}).
  - All-zero select gives 0.
  - Multi-hot select gives the bitwise OR of the selected slices; no priority.
- lk_mux = onehot mux of lk_dest_all_in by vc_d.
- ovc = onehot mux of assigned_ovc_num by vc_d.
- lk_dest = lk_mux (bypass variant: see Optional Feature).
- hdr = MULTI_FLIT ? flit_in[Fw-1] : 1.
- dest_coded:
  - ADAPTIVE = 0: dest_coded = lk_dest.
  - ADAPTIVE = 1: dest_coded[DSTPw-1:2] = lk_dest[DSTPw-1:2].
  - ADAPTIVE = 1: dest_coded[1:0] = lk_dest[1:0] if (|(sel & vc_d)) is 1, else flit_in[DST_P_LSB+1:DST_P_LSB].
- flit_out = {flit_in[Fw-1:Fw-2], ovc, flit_in[FPAYw-1:0]}. If hdr = 1, flit_out[DST_P_MSB:DST_P_LSB] = dest_coded.
- Body and tail flits: only the VC field changes.
- Latency: flit path is zero-cycle combinational; VC select has one cycle of latency.
- During reset: vc_d = 0, so ovc = 0 and the VC field is 0. A header flit's dest field is then 0 (deterministic), or {0, flit_in dest[1:0]} (adaptive).
- No handshake; the block is fully transparent every cycle.

Optional Feature:
- Macro: HDR_SSA_BYPASS_EN.
- Defined:
  - The gnt_d register exists.
  - lk_dest = (gnt_d == 0) ? lk_dest_not_registered : lk_mux.
  - This bypasses the look-ahead FIFO for single-cycle speculative switch allocation.
- Undefined:
  - No gnt_d register.
  - lk_dest = lk_mux always.
  - any_ivc_sw_request_granted and lk_dest_not_registered are ignored.

Test Plan:
- Reset low, then flit_in header with dest field 4'hF → VC field of flit_out = 0. After reset release and vc_num_in=0001 clocked: VC field = assigned_ovc_num slice 0.
- ADAPTIVE=0. Clock vc_num_in=0100, lk_dest slice 2 = 4'hA, assigned slice 2 = 0010. Header flit → dest field A, VC field 0010, all other bits equal to flit_in.
- Same setup with a body flit (bit Fw-1 = 0), dest field 4'h3 → dest field stays 3; only VC field changes.
- ADAPTIVE=1, vc_d=0010, lk slice 1 = 4'b1101, flit dest = 4'b0010:
  - sel=0010 → dest 1101.
  - sel=0000 → dest 1110.
- Multi-hot vc_d=0011, slices 0 = 4'h1 and 1 = 4'h2 → dest 4'h3 (OR). vc_d=0000 → dest 0, ovc 0.
- HDR_SSA_BYPASS_EN defined:
  - any_ivc_sw_request_granted=0 clocked, lk_dest_not_registered=4'h5 → dest 5.
  - Granted=1 clocked → dest = muxed slice.
